// File: rtl/isa_io_initiator.sv
// isa_io_initiator: ISA host-side I/O/memory cycle initiator; define ISA_TIMEOUT_EN to bound bus_rdy wait states
`timescale 1ns/1ps
module isa_io_initiator #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 6,
    parameter int HOLD_CYCLES   = 1,
    parameter int RDY_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [19:0] bus_a,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic [7:0]  bus_d_out,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_d_in,
    output logic        bus_aen,
    input  logic        bus_rdy
);
    localparam int CW = $clog2(SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES + RDY_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0] strb_l;
    logic io_q, wr_q, rdy_m, rdy_s, accept, go_strobe, exit_strobe, timed_out;
    assign req_ready = state == IDLE && !reset;
    assign rsp_valid = state == HOLD && cnt == '0;
    assign bus_aen = 1'b0;
    assign {bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l} = strb_l;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        accept = 1'b0;
        go_strobe = 1'b0;
        exit_strobe = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                accept = 1'b1;
                state_n = SETUP;
                cnt_n = CW'(SETUP_CYCLES - 1);
            end
            SETUP: if (cnt == '0) begin
                go_strobe = 1'b1;
                state_n = STROBE;
                cnt_n = CW'(STROBE_CYCLES - 1);
            end else cnt_n = cnt - CW'(1);
            STROBE: if (cnt != '0) cnt_n = cnt - CW'(1);
            else if (rdy_s || timed_out) begin
                exit_strobe = 1'b1;
                state_n = HOLD;
                cnt_n = CW'(HOLD_CYCLES - 1);
            end
            HOLD: if (cnt == '0) state_n = IDLE;
            else cnt_n = cnt - CW'(1);
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            rdy_m <= 1'b1;
            rdy_s <= 1'b1;
            strb_l <= 4'hF;
            io_q <= 1'b0;
            wr_q <= 1'b0;
            bus_a <= '0;
            bus_d_out <= '0;
            bus_d_oe <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            rdy_m <= bus_rdy;
            rdy_s <= rdy_m;
            if (accept) begin
                io_q <= req_io;
                wr_q <= req_write;
                bus_a <= req_io ? {4'h0, req_addr[15:0]} : req_addr;
                bus_d_out <= req_wdata;
                bus_d_oe <= req_write;
            end
            if (go_strobe) strb_l <= ~(4'b0001 << {io_q, wr_q});
            if (exit_strobe) begin
                strb_l <= 4'hF;
                if (!wr_q) rsp_rdata <= timed_out ? 8'hFF : bus_d_in;
            end
            if (rsp_valid) bus_d_oe <= 1'b0;
        end
    end
`ifdef ISA_TIMEOUT_EN
    logic [CW-1:0] tcnt;
    logic err_q;
    assign timed_out = state == STROBE && cnt == '0 && !rdy_s && tcnt == CW'(RDY_TIMEOUT);
    assign rsp_err = rsp_valid && err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
            err_q <= 1'b0;
        end else begin
            if (go_strobe) tcnt <= '0;
            else if (state == STROBE && cnt == '0 && !rdy_s) tcnt <= tcnt + CW'(1);
            if (accept) err_q <= 1'b0;
            else if (exit_strobe) err_q <= timed_out;
        end
    end
`else
    assign timed_out = 1'b0;
    assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_isa_io_initiator.sv
// tb_isa_io_initiator: cycle-number reference model of isa_io_initiator plus directed and random traffic
`timescale 1ns/1ps
module tb_isa_io_initiator;
    localparam int SETUP = 2, STRB = 6, HOLD = 1, TMO = 255;
`ifdef ISA_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0, req_io = 1'b0;
    logic [19:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic [19:0] bus_a;
    logic bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_d_oe, bus_aen;
    logic [7:0] bus_d_out, bus_d_in = '0;
    logic bus_rdy = 1'b1;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    isa_io_initiator dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .bus_a(bus_a),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
        .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_d_in(bus_d_in), .bus_aen(bus_aen), .bus_rdy(bus_rdy)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask
    // Transaction model: each request is a set of cycle numbers (strobe start, exit, response).
    int cyc = 0, s0 = 0, e = -1;
    bit busy = 0, m_wr = 0, m_io = 0, m_err = 0, sy_m = 1, sy_s = 1, on = 0;
    logic [19:0] m_a = '0;
    logic [7:0] m_dout = '0, m_rdata = '0;
    always @(posedge clk) begin
        if (reset) begin
            busy = 0;
            m_a = '0;
            m_dout = '0;
            m_rdata = '0;
            m_err = 0;
        end else if (!busy && req_valid) begin
            busy = 1;
            s0 = cyc + 1 + SETUP;
            e = -1;
            m_wr = req_write;
            m_io = req_io;
            m_a = req_io ? {4'h0, req_addr[15:0]} : req_addr;
            m_dout = req_wdata;
            m_err = 0;
        end else if (busy) begin
            if (e < 0 && cyc >= s0 + STRB - 1 && (sy_s || (TMO_EN && cyc == s0 + STRB - 1 + TMO))) begin
                e = cyc;
                m_err = !sy_s;
                if (!m_wr) m_rdata = sy_s ? bus_d_in : 8'hFF;
            end
            if (e >= 0 && cyc == e + HOLD) busy = 0;
        end
        sy_s = reset ? 1'b1 : sy_m;
        sy_m = reset ? 1'b1 : bus_rdy;
        cyc++;
    end
    always @(negedge clk) begin
        on = busy && cyc >= s0 && (e < 0 || cyc <= e);
        chk("req_ready", req_ready, !busy && !reset);
        chk("iow_l", bus_iow_l, !(on && m_io && m_wr));
        chk("ior_l", bus_ior_l, !(on && m_io && !m_wr));
        chk("memw_l", bus_memw_l, !(on && !m_io && m_wr));
        chk("memr_l", bus_memr_l, !(on && !m_io && !m_wr));
        chk("rsp_valid", rsp_valid, busy && e >= 0 && cyc == e + HOLD);
        chk("rsp_err", rsp_err, busy && e >= 0 && cyc == e + HOLD && m_err);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("bus_a", bus_a, m_a);
        chk("bus_d_out", bus_d_out, m_dout);
        chk("bus_d_oe", bus_d_oe, busy && m_wr);
        chk("bus_aen", bus_aen, 0);
    end
    int run = 0, last_len = 0, st_start = 0, rv_cnt = 0, overlap = 0;
    logic [3:0] low_vec, cur_vec = '0, last_vec = '0;
    logic [7:0] rv_data = '0;
    logic rv_err = 1'b0;
    bit oe_seen = 0;
    always @(negedge clk) begin
        low_vec = ~{bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l};
        if ($countones(low_vec) > 1) overlap++;
        if (low_vec != 0) begin
            if (run == 0) begin
                st_start = cyc;
                cur_vec = low_vec;
            end
            run++;
        end else if (run != 0) begin
            last_len = run;
            last_vec = cur_vec;
            run = 0;
        end
        if (rsp_valid) begin
            rv_cnt++;
            rv_data = rsp_rdata;
            rv_err = rsp_err;
        end
        if (bus_d_oe) oe_seen = 1;
    end
    bit rdy_auto = 1, din_auto = 1;
    int rdy_left = 0, acc_cyc = 0;
    task automatic step();
        @(posedge clk);
        #1;
        if (din_auto) bus_d_in = 8'($urandom);
        if (rdy_auto) begin
            if (rdy_left == 0 && $urandom_range(0, 11) == 0) rdy_left = $urandom_range(1, 15);
            bus_rdy = rdy_left == 0;
            if (rdy_left != 0) rdy_left--;
        end
    endtask
    task automatic issue(input bit wr, input bit io, input logic [19:0] a, input logic [7:0] d);
        bit fired = 0;
        req_valid = 1;
        req_write = wr;
        req_io = io;
        req_addr = a;
        req_wdata = d;
        for (int i = 0; i < 600 && !fired; i++) begin
            @(negedge clk);
            fired = req_ready;
            if (fired) acc_cyc = cyc;
            step();
        end
        chk("accept_seen", fired, 1);
        req_valid = 0;
        req_write = 1'($urandom);
        req_io = 1'($urandom);
        req_addr = 20'($urandom);
        req_wdata = 8'($urandom);
    endtask
    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
            step();
        end
        chk("rsp_seen", seen, 1);
    endtask
    int a1 = 0, rv0 = 0, k = 0;
    initial begin
        rdy_auto = 0;
        repeat (3) step();
        chk("rst_bus_a", bus_a, 0);
        chk("rst_strobes", {bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l}, 4'hF);
        chk("rst_ready", req_ready, 0);
        chk("rst_oe", bus_d_oe, 0);
        chk("rst_rdata", rsp_rdata, 0);
        reset = 0;
        step();
        oe_seen = 0;
        issue(1, 1, 20'h003B8, 8'h0A);
        wait_done();
        chk("iow_len", last_len, 6);
        chk("iow_kind", last_vec, 4'b1000);
        chk("iow_setup_gap", st_start - (acc_cyc + 1), 2);
        chk("iow_addr", bus_a, 20'h003B8);
        chk("iow_dout", bus_d_out, 8'h0A);
        chk("iow_err", rv_err, 0);
        chk("iow_oe_seen", oe_seen, 1);
        din_auto = 0;
        bus_d_in = 8'h8F;
        oe_seen = 0;
        issue(0, 1, 20'hF03BA, 8'h33);
        wait_done();
        chk("ior_len", last_len, 6);
        chk("ior_kind", last_vec, 4'b0100);
        chk("ior_addr", bus_a, 20'h003BA);
        chk("ior_rdata", rv_data, 8'h8F);
        chk("ior_oe", oe_seen, 0);
        din_auto = 1;
        issue(0, 0, 20'hB0001, 8'h00);
        bus_rdy = 0;
        repeat (12) step();
        bus_rdy = 1;
        wait_done();
        chk("memr_wait_len", last_len, 13);
        chk("memr_kind", last_vec, 4'b0001);
        issue(1, 1, 20'h003B4, 8'h0C);
        a1 = acc_cyc;
        issue(1, 1, 20'h003B5, 8'h00);
        wait_done();
        chk("b2b_gap", acc_cyc - a1, 1 + SETUP + STRB + HOLD);
        chk("b2b_dout", bus_d_out, 8'h00);
        rv0 = rv_cnt;
        issue(1, 0, 20'hB0010, 8'h77);
        repeat (4) step();
        chk("mid_strobe_low", bus_memw_l, 0);
        reset = 1;
        step();
        reset = 0;
        chk("abort_strobes", {bus_iow_l, bus_ior_l, bus_memw_l, bus_memr_l}, 4'hF);
        chk("abort_oe", bus_d_oe, 0);
        repeat (15) step();
        chk("abort_no_rsp", rv_cnt, rv0);
        issue(0, 1, 20'h003BF, 8'h00);
        wait_done();
        chk("after_abort_rsp", rv_cnt, rv0 + 1);
`ifdef ISA_TIMEOUT_EN
        bus_rdy = 0;
        issue(0, 1, 20'h003BA, 8'h00);
        wait_done();
        bus_rdy = 1;
        chk("tmo_len", last_len, STRB + TMO);
        chk("tmo_err", rv_err, 1);
        chk("tmo_rdata", rv_data, 8'hFF);
`endif
        rdy_auto = 1;
        for (int n = 0; n < 150; n++) begin
            issue(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom));
            k = $urandom_range(0, 39);
            if (k == 0) begin
                repeat ($urandom_range(0, 10)) step();
                reset = 1;
                step();
                reset = 0;
            end else if (k < 20) repeat ($urandom_range(0, 3)) step();
        end
        rdy_auto = 0;
        bus_rdy = 1;
        repeat (40) step();
        chk("no_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
